drum_timing_ctl: RTL and testbench

- Generates bit-time and word-time timing for the recirculating drum lines.
- Each long line is 3132 bits: 108 words of 29 bits, one bit per CLOCK.
- Schedules line transfers: a requester names a starting word and a length, and the block raises the transfer gate (TR) for exactly that drum window, then reports completion.
- Sits between the command/control logic and the memory line block (lines 0–6), which consumes TR and the timing pulses.

---
 rtl/drum_timing_ctl.sv | 137 +++++++++++++
 tb/tb_drum_timing_ctl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_timing_ctl.sv
// Drum bit/word timing generator and line-transfer scheduler.
// Free-running bit/word counters; TR is gated for one word or one full line starting at a target word.
module drum_timing_ctl #(
    parameter int WORD_BITS  = 29,
    parameter int LINE_WORDS = 108,
    parameter int WW         = 7
) (
    input  logic          CLOCK,
    input  logic          rst,
    input  logic          xfer_req,
    input  logic [WW-1:0] xfer_word,
    input  logic          xfer_full,
    input  logic          xfer_abort,
    output logic [4:0]    bit_time,
    output logic [WW-1:0] word_time,
    output logic          T0,
    output logic          T28,
    output logic          LINE_START,
    output logic          ODD_WORD,
    output logic          TR,
    output logic          xfer_busy,
    output logic          xfer_done,
    output logic          xfer_err
);

    localparam int LINE_BITS = WORD_BITS * LINE_WORDS;
    localparam int CW        = $clog2(LINE_BITS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

    state_t        r_state;
    logic [4:0]    r_bit;
    logic [WW-1:0] r_word;
    logic [WW-1:0] r_target;
    logic [CW-1:0] r_len_m1;
    logic [CW-1:0] r_cnt;
    logic          r_tr;
    logic          r_done;
    logic          r_err;

    logic          w_bit_wrap;
    logic [4:0]    w_bit_nxt;
    logic [WW-1:0] w_word_nxt;
    logic          w_word_ok;
    logic [CW-1:0] w_len_m1;
    logic          w_hit_req;
    logic          w_hit_tgt;

    assign w_bit_wrap = (r_bit == 5'(WORD_BITS - 1));
    assign w_bit_nxt  = w_bit_wrap ? 5'd0 : r_bit + 5'd1;
    assign w_word_nxt = !w_bit_wrap ? r_word :
                        (r_word == WW'(LINE_WORDS - 1)) ? '0 : r_word + WW'(1);
    assign w_word_ok  = (xfer_word < WW'(LINE_WORDS));
    assign w_len_m1   = xfer_full ? CW'(LINE_BITS - 1) : CW'(WORD_BITS - 1);

    // TR is registered, so the start decision looks at the counter values of the next cycle.
    assign w_hit_req  = (w_bit_nxt == 5'd0) && (w_word_nxt == xfer_word);
    assign w_hit_tgt  = (w_bit_nxt == 5'd0) && (w_word_nxt == r_target);

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_bit  <= '0;
            r_word <= '0;
        end else begin
            r_bit  <= w_bit_nxt;
            r_word <= w_word_nxt;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tr    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tr <= 1'b0;
                    if (xfer_req && !w_word_ok) begin
                        r_err <= 1'b1;
                    end else if (xfer_req && !xfer_abort) begin
                        r_target <= xfer_word;
                        r_len_m1 <= w_len_m1;
                        if (w_hit_req) begin
                            r_state <= S_XFER;
                            r_tr    <= 1'b1;
                            r_cnt   <= w_len_m1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (xfer_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_hit_tgt) begin
                        r_state <= S_XFER;
                        r_tr    <= 1'b1;
                        r_cnt   <= r_len_m1;
                    end
                end
                S_XFER: begin
                    // Abort takes priority over a completion in the same cycle.
                    if (xfer_abort) begin
                        r_state <= S_IDLE;
                        r_tr    <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_tr    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tr    <= 1'b0;
                end
            endcase
        end
    end

    assign bit_time   = r_bit;
    assign word_time  = r_word;
    assign T0         = (r_bit == 5'd0);
    assign T28        = w_bit_wrap;
    assign LINE_START = (r_bit == 5'd0) && (r_word == '0);
    assign ODD_WORD   = r_word[0];
    assign TR         = r_tr;
    assign xfer_busy  = (r_state != S_IDLE);
    assign xfer_done  = r_done;
    assign xfer_err   = r_err;

endmodule

// File: tb/tb_drum_timing_ctl.sv
// Directed bench for drum_timing_ctl: timing counters, transfer windows, errors, abort and reset.
module tb_drum_timing_ctl;

    localparam int WB = 29;
    localparam int LW = 108;
    localparam int WW = 7;

    logic          CLOCK = 1'b0;
    logic          rst = 1'b1;
    logic          xfer_req = 1'b0;
    logic [WW-1:0] xfer_word = '0;
    logic          xfer_full = 1'b0;
    logic          xfer_abort = 1'b0;
    logic [4:0]    bit_time;
    logic [WW-1:0] word_time;
    logic          T0, T28, LINE_START, ODD_WORD, TR, xfer_busy, xfer_done, xfer_err;

    int checks = 0;
    int errors = 0;
    int m_cyc = 0;
    int timing_bad = 0;

    drum_timing_ctl #(.WORD_BITS(WB), .LINE_WORDS(LW), .WW(WW)) dut (
        .CLOCK(CLOCK), .rst(rst), .xfer_req(xfer_req), .xfer_word(xfer_word),
        .xfer_full(xfer_full), .xfer_abort(xfer_abort), .bit_time(bit_time),
        .word_time(word_time), .T0(T0), .T28(T28), .LINE_START(LINE_START),
        .ODD_WORD(ODD_WORD), .TR(TR), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .xfer_err(xfer_err)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_bit();
        return m_cyc % WB;
    endfunction

    function automatic int cur_word();
        return (m_cyc / WB) % LW;
    endfunction

    // Advance one clock and compare the timing outputs against the cycle-count model.
    task automatic tick();
        logic was_rst;
        int eb, ew;
        was_rst = rst;
        @(posedge CLOCK);
        #1;
        if (was_rst) m_cyc = 0;
        else m_cyc++;
        eb = cur_bit();
        ew = cur_word();
        if (bit_time !== 5'(eb) || word_time !== WW'(ew) || T0 !== (eb == 0) ||
            T28 !== (eb == WB - 1) || LINE_START !== (eb == 0 && ew == 0) ||
            ODD_WORD !== (ew % 2 == 1))
            timing_bad++;
    endtask

    task automatic goto_pos(input int w, input int b);
        int n;
        n = 0;
        while (!(cur_word() == w && cur_bit() == b) && n < 3200) begin
            tick();
            n++;
        end
        chk("goto_in_budget", 32'(n < 3200), 1);
    endtask

    task automatic request(input int w, input logic full);
        xfer_req  = 1'b1;
        xfer_word = WW'(w);
        xfer_full = full;
        tick();
        xfer_req  = 1'b0;
    endtask

    // Called in the cycle after acceptance; follows the wait, the gated window and the done pulse.
    task automatic observe_xfer(input string tag, input int exp_word, input int exp_len,
                                input int exp_wait, input logic full,
                                input logic chain, input int chain_word);
        int n, len, busy_bad, end_word;
        n = 0;
        busy_bad = 0;
        while (TR !== 1'b1 && n < 3300) begin
            if (xfer_busy !== 1'b1 || xfer_done !== 1'b0) busy_bad++;
            tick();
            n++;
        end
        chk({tag, "_wait"}, n, exp_wait);
        chk({tag, "_start_word"}, 32'(word_time), exp_word);
        chk({tag, "_start_bit"}, 32'(bit_time), 0);
        len = 0;
        while (TR === 1'b1 && len < 3300) begin
            if (xfer_busy !== 1'b1 || xfer_done !== 1'b0) busy_bad++;
            tick();
            len++;
        end
        end_word = full ? exp_word : (exp_word + 1) % LW;
        chk({tag, "_len"}, len, exp_len);
        chk({tag, "_end_word"}, 32'(word_time), end_word);
        chk({tag, "_done"}, 32'(xfer_done), 1);
        chk({tag, "_busy_end"}, 32'(xfer_busy), 0);
        chk({tag, "_busy_during"}, busy_bad, 0);
        if (chain) begin
            request(chain_word, 1'b0);
            chk({tag, "_chain_busy"}, 32'(xfer_busy), 1);
        end else begin
            tick();
            chk({tag, "_busy_after"}, 32'(xfer_busy), 0);
        end
        chk({tag, "_done_once"}, 32'(xfer_done), 0);
    endtask

    initial begin
        int ls_cnt, t28_cnt, odd_tog, dn, n;
        logic prev_odd;

        // Reset values.
        tick();
        tick();
        rst = 1'b0;
        chk("rst_bit", 32'(bit_time), 0);
        chk("rst_word", 32'(word_time), 0);
        chk("rst_T0", 32'(T0), 1);
        chk("rst_LINE_START", 32'(LINE_START), 1);
        chk("rst_T28", 32'(T28), 0);
        chk("rst_ODD", 32'(ODD_WORD), 0);
        chk("rst_TR", 32'(TR), 0);
        chk("rst_busy", 32'(xfer_busy), 0);
        chk("rst_done", 32'(xfer_done), 0);
        chk("rst_err", 32'(xfer_err), 0);

        // Two free-running line revolutions.
        ls_cnt = 0;
        t28_cnt = 0;
        odd_tog = 0;
        prev_odd = ODD_WORD;
        for (int i = 0; i < 6264; i++) begin
            tick();
            if (LINE_START === 1'b1) ls_cnt++;
            if (T28 === 1'b1) t28_cnt++;
            if (ODD_WORD !== prev_odd) odd_tog++;
            prev_odd = ODD_WORD;
        end
        chk("free_line_start", ls_cnt, 2);
        chk("free_t28", t28_cnt, 216);
        chk("free_odd_toggles", odd_tog, 216);
        chk("free_timing", timing_bad, 0);

        // Single word 5 requested at word 2.
        goto_pos(2, 0);
        request(5, 1'b0);
        observe_xfer("single5", 5, 29, 86, 1'b0, 1'b0, 0);

        // Full line from word 100, wrapping 107 -> 0.
        goto_pos(98, 0);
        request(100, 1'b1);
        observe_xfer("full100", 100, 3132, 57, 1'b1, 1'b0, 0);

        // Out-of-range word is rejected.
        request(108, 1'b0);
        chk("bad108_err", 32'(xfer_err), 1);
        chk("bad108_busy", 32'(xfer_busy), 0);
        chk("bad108_tr", 32'(TR), 0);
        tick();
        chk("bad108_err_pulse", 32'(xfer_err), 0);
        chk("bad108_busy2", 32'(xfer_busy), 0);

        // Highest legal word.
        goto_pos(105, 0);
        request(107, 1'b0);
        chk("w107_err", 32'(xfer_err), 0);
        observe_xfer("w107", 107, 29, 57, 1'b0, 1'b0, 0);

        // Requesting word 7 while the counters show word 7 bit 0 costs a full revolution.
        goto_pos(7, 0);
        request(7, 1'b0);
        observe_xfer("w7_rev", 7, 29, 3131, 1'b0, 1'b0, 0);

        // Back-to-back: new request issued in the done cycle.
        goto_pos(38, 0);
        request(40, 1'b0);
        observe_xfer("b2b_first", 40, 29, 57, 1'b0, 1'b1, 45);
        observe_xfer("b2b_second", 45, 29, 115, 1'b0, 1'b0, 0);

        // Requests while busy are ignored, including out-of-range ones.
        goto_pos(50, 0);
        request(60, 1'b0);
        xfer_req = 1'b1;
        xfer_word = WW'(55);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) xfer_word = WW'(120);
            tick();
            if (xfer_err !== 1'b0 || xfer_busy !== 1'b1) n++;
        end
        xfer_req = 1'b0;
        chk("busy_req_ignored", n, 0);
        observe_xfer("busy60", 60, 29, 283, 1'b0, 1'b0, 0);
        dn = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (xfer_done === 1'b1 || xfer_busy === 1'b1) dn++;
        end
        chk("busy_no_extra", dn, 0);

        // Abort at the 10th gated cycle.
        request(20, 1'b0);
        n = 0;
        while (TR !== 1'b1 && n < 3300) begin
            tick();
            n++;
        end
        chk("abort_tr_seen", 32'(n < 3300), 1);
        for (int i = 0; i < 9; i++) tick();
        chk("abort_tr_10th", 32'(TR), 1);
        xfer_abort = 1'b1;
        tick();
        xfer_abort = 1'b0;
        chk("abort_tr", 32'(TR), 0);
        chk("abort_busy", 32'(xfer_busy), 0);
        chk("abort_done", 32'(xfer_done), 0);
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (xfer_done === 1'b1 || TR === 1'b1) dn++;
        end
        chk("abort_quiet", dn, 0);

        // Reset during a full-line transfer.
        request(30, 1'b1);
        n = 0;
        while (TR !== 1'b1 && n < 3300) begin
            tick();
            n++;
        end
        chk("rst_xfer_tr_seen", 32'(n < 3300), 1);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstx_bit", 32'(bit_time), 0);
        chk("rstx_word", 32'(word_time), 0);
        chk("rstx_T0", 32'(T0), 1);
        chk("rstx_LINE_START", 32'(LINE_START), 1);
        chk("rstx_TR", 32'(TR), 0);
        chk("rstx_busy", 32'(xfer_busy), 0);
        chk("rstx_done", 32'(xfer_done), 0);
        chk("rstx_err", 32'(xfer_err), 0);
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (xfer_done === 1'b1 || TR === 1'b1 || xfer_busy === 1'b1) dn++;
        end
        chk("rstx_quiet", dn, 0);
        chk("timing_overall", timing_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
